data_sync_ctrl: RTL and testbench



---
 rtl/data_sync_pkg.sv | 21 ++
 rtl/data_sync.sv | 43 ++++
 rtl/data_sync_ctrl.sv | 124 ++++++++++++
 tb/tb_data_sync_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// -----------------------------------------------------------------------------
// data_sync_pkg
// Shared types and constants for the data_sync_ctrl slice.
//   ds_state_t         : controller state (IDLE, SETTLE, HOLD)
//   MIN_S_STAGES       : fewest synchronizer stages that still resolve metastability
//   MIN_STABLE_CYCLES  : fewest matching cycles a value must hold before commit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } ds_state_t;

    localparam int MIN_S_STAGES      = 2;
    localparam int MIN_STABLE_CYCLES = 1;

endpackage

// File: rtl/data_sync.sv
// -----------------------------------------------------------------------------
// data_sync
// Plain multi-bit flop-chain synchronizer. Each bit is synchronized on its own,
// so a bus that changes while being sampled may show a mixed word for a cycle;
// the controller above filters that out.
// Ports:
//   clk_i    in   destination clock
//   rst_n_i  in   asynchronous active-low reset, clears every stage
//   data_i   in   asynchronous input bus
//   sync_o   out  bus after S_STAGES flops
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module data_sync #(
    parameter int D_WIDTH  = 8,
    parameter int S_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [D_WIDTH-1:0] data_i,
    output logic [D_WIDTH-1:0] sync_o
);

    logic [D_WIDTH-1:0] stage_q [S_STAGES];

    // Shift the raw bus through the flop chain; stage 0 is the only flop that
    // can go metastable, later stages give it time to resolve.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < S_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < S_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[S_STAGES-1];

endmodule

// File: rtl/data_sync_ctrl.sv
// -----------------------------------------------------------------------------
// data_sync_ctrl
// Brings an asynchronous bus into clk_i, waits until the synchronized value has
// held steady for STABLE_CYCLES further cycles, then commits it and offers it on
// a valid/ready handshake. Glitches that return to the committed value are
// dropped without a handshake.
// Ports:
//   clk_i      in   system clock
//   rst_n_i    in   asynchronous active-low reset
//   data_i     in   asynchronous input bus (D_WIDTH)
//   ready_i    in   consumer accepts data_o (only looked at while valid_o = 1)
//   data_o     out  last committed word
//   valid_o    out  data_o holds a new, unaccepted word
//   busy_o     out  controller is not IDLE
//   restart_o  out  one-cycle pulse when a running stability count restarts
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module data_sync_ctrl
    import data_sync_pkg::*;
#(
    parameter int D_WIDTH       = 8,
    parameter int S_STAGES      = 2,
    parameter int STABLE_CYCLES = 4,
    localparam int CNT_WIDTH    = $clog2(STABLE_CYCLES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               ready_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               restart_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

    // Parameter sanity, caught at elaboration rather than as odd behaviour.
    if (S_STAGES < MIN_S_STAGES) begin : g_bad_stages
        $error("data_sync_ctrl: S_STAGES must be at least %0d", MIN_S_STAGES);
    end
    if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable
        $error("data_sync_ctrl: STABLE_CYCLES must be at least %0d", MIN_STABLE_CYCLES);
    end

    logic [D_WIDTH-1:0]   sync_q;
    ds_state_t            state_q;
    logic [D_WIDTH-1:0]   cand_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    data_sync #(
        .D_WIDTH  (D_WIDTH),
        .S_STAGES (S_STAGES)
    ) u_data_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .sync_o  (sync_q)
    );

    // Controller FSM with its counter and all outputs registered in one place.
    // busy_o is written together with every state change so it always equals
    // (state_q != IDLE) without a combinational decode on the output.
    // A candidate is committed after it was seen on entry plus STABLE_CYCLES
    // further matching cycles; any mismatch restarts the count on the new value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            restart_o <= 1'b0;
        end else begin
            restart_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_q != data_o) begin
                        state_q <= SETTLE;
                        busy_o  <= 1'b1;
                        cand_q  <= sync_q;
                        cnt_q   <= '0;
                    end
                end
                SETTLE: begin
                    if (sync_q != cand_q) begin
                        cand_q    <= sync_q;
                        cnt_q     <= '0;
                        restart_o <= 1'b1;
                    end else if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        if (cand_q != data_o) begin
                            data_o  <= cand_q;
                            valid_o <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            // Glitch settled back on the committed word: nothing new to offer.
                            state_q <= IDLE;
                            busy_o  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    // Input changes are not queued; IDLE picks up whatever is current.
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_sync_ctrl
// Self-checking bench for data_sync_ctrl with the default parameters. Directed
// scenarios plus a randomized phase are compared each cycle against a
// reference model that tracks the synchronizer delay with a history array and
// the stability rule as "number of consecutive sightings of the candidate".
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_data_sync_ctrl;

    localparam int DW     = 8;
    localparam int STAGES = 2;
    localparam int STABLE = 4;

    logic          clk_i;
    logic          rst_n_i;
    logic [DW-1:0] data_i;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          busy_o;
    logic          restart_o;

    int checkCount;
    int failCount;

    // Reference model state
    logic [DW-1:0] hist [STAGES];
    logic [DW-1:0] modelData;
    logic          modelValid;
    logic          modelBusy;
    logic          modelRestart;
    logic          settling;
    logic [DW-1:0] candWord;
    int            seen;

    data_sync_ctrl #(
        .D_WIDTH       (DW),
        .S_STAGES      (STAGES),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .data_i    (data_i),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .restart_o (restart_o)
    );

    // Free-running 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Everything cleared, as after reset.
    task automatic modelReset();
        for (int i = 0; i < STAGES; i++) hist[i] = '0;
        modelData    = '0;
        modelValid   = 1'b0;
        modelBusy    = 1'b0;
        modelRestart = 1'b0;
        settling     = 1'b0;
        candWord     = '0;
        seen         = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    // The controller sees data_i as it was STAGES edges earlier. A candidate is
    // committed once it has been seen STABLE+1 times in a row.
    task automatic modelEdge();
        logic [DW-1:0] syncVal;
        syncVal = hist[STAGES-1];
        for (int i = STAGES-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = data_i;
        modelRestart = 1'b0;
        if (modelValid) begin
            if (ready_i) modelValid = 1'b0;
        end else if (!settling) begin
            if (syncVal != modelData) begin
                settling = 1'b1;
                candWord = syncVal;
                seen     = 1;
            end
        end else if (syncVal != candWord) begin
            candWord     = syncVal;
            seen         = 1;
            modelRestart = 1'b1;
        end else begin
            seen++;
            if (seen == STABLE + 1) begin
                settling = 1'b0;
                if (candWord != modelData) begin
                    modelData  = candWord;
                    modelValid = 1'b1;
                end
            end
        end
        modelBusy = settling || modelValid;
    endtask

    // Compare all outputs against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".data_o"},    32'(data_o),    32'(modelData));
        checkOutput({tag, ".valid_o"},   32'(valid_o),   32'(modelValid));
        checkOutput({tag, ".busy_o"},    32'(busy_o),    32'(modelBusy));
        checkOutput({tag, ".restart_o"}, 32'(restart_o), 32'(modelRestart));
    endtask

    // One clock cycle: drive inputs, let the edge happen, check on the falling edge.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic r, input string tag);
        data_i  = d;
        ready_i = r;
        @(posedge clk_i);
        if (rst_n_i) modelEdge();
        else modelReset();
        @(negedge clk_i);
        checkAll(tag);
    endtask

    // Step to a new value and count edges until valid_o rises (edge 0 = first
    // edge sampling the new value). Bounded so a stuck design still terminates.
    task automatic measureLatency(input logic [DW-1:0] d, input logic r, input string tag, output int n);
        applyStimulus(d, r, tag);
        n = 0;
        while (!valid_o && n < 40) begin
            applyStimulus(d, r, tag);
            n++;
        end
    endtask

    initial begin
        int n;
        int restartCount;
        int validCount;
        logic [DW-1:0] d;
        logic [DW-1:0] pool [4];

        checkCount = 0;
        failCount  = 0;
        pool[0] = 8'h11; pool[1] = 8'h22; pool[2] = 8'h5A; pool[3] = 8'hF0;

        // Reset state
        rst_n_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        modelReset();
        repeat (3) @(negedge clk_i);
        checkAll("reset");
        rst_n_i = 1'b1;

        // Idle with zero input: nothing happens
        for (int i = 0; i < 8; i++) applyStimulus(8'h00, 1'b0, "idle_zero");

        // Step to 0xA5 with ready held high: commit after edge 6, valid for one cycle
        measureLatency(8'hA5, 1'b1, "step_a5", n);
        checkOutput("a5_latency", 32'(n), 32'(STAGES + STABLE));
        checkOutput("a5_data", 32'(data_o), 32'h0000_00A5);
        applyStimulus(8'hA5, 1'b1, "step_a5");
        checkOutput("a5_valid_one_cycle", 32'(valid_o), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(8'hA5, 1'b1, "step_a5");

        // Toggling bus: restarts, no commit until 0xC3 holds
        restartCount = 0;
        validCount   = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i % 2 == 0) ? 8'h3C : 8'hC3, 1'b1, "toggle");
            restartCount += int'(restart_o);
            validCount   += int'(valid_o);
        end
        checkOutput("toggle_no_commit", 32'(validCount), 32'd0);
        checkOutput("toggle_restarts", 32'(restartCount >= 10), 32'd1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'hC3, 1'b1, "toggle_settle");
            validCount += int'(valid_o);
        end
        checkOutput("toggle_single_commit", 32'(validCount), 32'd1);
        checkOutput("toggle_data", 32'(data_o), 32'h0000_00C3);

        // Glitch away from and back to a committed value
        for (int i = 0; i < 10; i++) applyStimulus(8'h11, 1'b1, "glitch_pre");
        checkOutput("glitch_pre_data", 32'(data_o), 32'h0000_0011);
        validCount = 0;
        n = 0;
        applyStimulus(8'h55, 1'b1, "glitch");
        applyStimulus(8'h55, 1'b1, "glitch");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'h11, 1'b1, "glitch_post");
            validCount += int'(valid_o);
            n          += int'(busy_o);
        end
        checkOutput("glitch_no_valid", 32'(validCount), 32'd0);
        checkOutput("glitch_busy_seen", 32'(n > 0), 32'd1);
        checkOutput("glitch_data_kept", 32'(data_o), 32'h0000_0011);
        checkOutput("glitch_idle_after", 32'(busy_o), 32'd0);

        // Backpressure: 0x22 waits for ready, 0x44 follows after acceptance
        for (int i = 0; i < 9; i++) applyStimulus(8'h22, 1'b0, "bp_commit");
        checkOutput("bp_valid_held", 32'(valid_o), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(8'h44, 1'b0, "bp_hold");
        checkOutput("bp_data_frozen", 32'(data_o), 32'h0000_0022);
        applyStimulus(8'h44, 1'b1, "bp_accept");
        n = 0;
        while (!valid_o && n < 40) begin
            applyStimulus(8'h44, 1'b0, "bp_second");
            n++;
        end
        checkOutput("bp_second_latency", 32'(n), 32'(1 + STABLE));
        checkOutput("bp_second_data", 32'(data_o), 32'h0000_0044);
        applyStimulus(8'h44, 1'b1, "bp_second");

        // Reset during SETTLE discards the pending word
        for (int i = 0; i < 3; i++) applyStimulus(8'h7E, 1'b0, "rst_settle");
        checkOutput("rst_in_settle", 32'(busy_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        modelReset();
        checkAll("rst_async");
        @(negedge clk_i);
        applyStimulus(8'h7E, 1'b0, "rst_held");
        rst_n_i = 1'b1;
        measureLatency(8'h7E, 1'b1, "rst_release", n);
        checkOutput("rst_release_latency", 32'(n), 32'(STAGES + STABLE));
        checkOutput("rst_release_data", 32'(data_o), 32'h0000_007E);

        // Randomized phase against the model
        d = 8'h7E;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) d = pool[$urandom_range(0, 3)];
            applyStimulus(d, ($urandom_range(0, 2) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
